ring_counter_prog: RTL and testbench
====================================

# ring_counter_prog

Parametrised, programmable successor to the fixed 8-bit rotate-left ring counter. It generates one-hot ring, Johnson (twisted-ring) and one-hot bounce sequences of configurable width, with direction control, an enable-gated step prescaler and synchronous load. It also detects illegal states, corrects them and flags each correction. It sits between the top-level pin wrapper and the output pins, and drives LED/strobe-style patterns.

## Interface
Parameters:
- WIDTH, 8, counter width in bits; legal range is WIDTH >= 2.
- DIV_W, 8, width of the prescaler divide value.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  advances the prescaler and enables steps.
- mode  in  2  00 ring, 01 Johnson, 10 hold, 11 bounce.
- dir  in  1  0 = left (toward MSB), 1 = right (toward LSB).
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value written to q on load.
- div  in  DIV_W  one step every div+1 enabled cycles.
- q  out  WIDTH  counter state.
- tick  out  1  one-cycle pulse, asserted with every step.
- wrap  out  1  one-cycle pulse when a step lands on the start pattern.
- err  out  1  one-cycle pulse when a step corrected an illegal state.

## Operation
- Reset values: q = 1 (bit 0 set); tick, wrap and err = 0; prescaler count = 0; internal bounce direction = left.
- Prescaler:
  - pre_cnt increments while en=1 and load=0.
  - step = en & ~load & (pre_cnt == div). On a step, pre_cnt returns to 0.
  - With en=0, pre_cnt and q hold.
  - div=0 steps every enabled cycle.
  - If div is changed so that div < pre_cnt, pre_cnt wraps modulo 2^DIV_W before the next step occurs.
- Load:
  - Has priority over step and is independent of en.
  - Sets q = load_val and pre_cnt = 0.
  - Forces tick, wrap and err to 0.
  - Sets the bounce direction from dir.
  - load_val is not checked at load time; an illegal value is corrected at the next step.
- Ring (00):
  - dir=0 rotates left (MSB wraps to LSB); dir=1 rotates right.
  - Legal states have exactly one bit set.
- Johnson (01):
  - dir=0: q <= {q[W-2:0], ~q[W-1]}. dir=1: q <= {~q[0], q[W-1:1]}.
  - Legal state: at most one adjacent-bit transition among q[i]^q[i+1], i = 0..W-2.
  - Period is 2*WIDTH.
- Hold (10): a step still pulses tick. q does not change; wrap=0 and err=0.
- Bounce (11):
  - One-hot; shifts in the internal direction bdir.
  - When a step reaches the end bit (MSB going left, LSB going right), bdir reverses, so the next step leaves that end.
  - The dir input is ignored in this mode.
  - While mode != 11, bdir tracks dir every cycle.
  - Period is 2*WIDTH-2. For WIDTH=4 the sequence is 0001, 0010, 0100, 1000, 0100, 0010, 0001.
- Correction (modes 00, 01, 11):
  - Checked only on a step.
  - An illegal q is replaced by the start pattern instead of the shifted value, and err pulses.
  - Start pattern: 1 for ring and bounce; all zeros for Johnson.
- wrap pulses on a non-correcting step whose new q equals the start pattern. A correcting step never pulses wrap.
- Mode or dir changes apply from the next step; no partial steps.

## Timing
- Single-cycle: the edge that registers step updates q and raises tick, wrap and err together. All three pulses align with the new q value for exactly one cycle.
- All outputs come directly from flops; there is no combinational input-to-output path.
- Reset may assert mid-sequence at any time. Deassertion must be synchronised externally; the first step can occur div+1 enabled cycles after release.
- Load and step in the same cycle: load wins, no tick.

## Structure
- Package ring_counter_prog_pkg holds:
  - mode constants MODE_RING, MODE_JOHNSON, MODE_HOLD, MODE_BOUNCE;
  - direction constants DIR_LEFT, DIR_RIGHT;
  - legality-check functions is_onehot and is_johnson, parametrised by width.
- Sub-module step_prescaler (DIV_W): inputs en, clr, div; output step. The shift, correction and flag logic stays in the top module.

## Test plan
- Reset, ring, dir=0, div=0, en=1: q = 01, 02, 04 … 80, 01. wrap pulses at the 01 edge; tick pulses every cycle.
- Johnson, WIDTH=4, div=2: q = 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, stepping every 3rd cycle. wrap pulses on the return to 0000.
- Bounce, WIDTH=4: the sequence 0001 … 1000 … 0001 has period 6. Toggling dir mid-run has no effect.
- Load 0x05 in ring mode, then one step: q = 01, err pulses, wrap = 0. Load and en asserted in the same cycle gives no tick.
- en dropped mid-prescale with div=3: q and the count hold. After en is restored, the remaining count completes before the next step. Reset mid-run: q returns to 01 immediately.

Source files
------------

// File: rtl/ring_counter_prog_pkg.sv
// Shared constants and legality checks for the programmable ring counter.
// The checks take a zero-extended vector plus the real width so one function serves every WIDTH.
package ring_counter_prog_pkg;

    typedef enum logic [1:0] {
        MODE_RING    = 2'b00,
        MODE_JOHNSON = 2'b01,
        MODE_HOLD    = 2'b10,
        MODE_BOUNCE  = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Widest counter the legality checks can inspect.
    localparam int MAX_W = 64;

    function automatic logic is_onehot(input logic [MAX_W-1:0] v, input int w);
        int ones;
        ones = 0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w && v[i]) ones++;
        end
        return ones == 1;
    endfunction

    function automatic logic is_johnson(input logic [MAX_W-1:0] v, input int w);
        int edges;
        edges = 0;
        for (int i = 0; i < MAX_W - 1; i++) begin
            if (i < w - 1 && (v[i] ^ v[i+1])) edges++;
        end
        return edges <= 1;
    endfunction

endpackage

// File: rtl/ring_counter_prog_step_prescaler.sv
// Enable-gated step prescaler: one step every div+1 enabled cycles, cleared by a load.
module step_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             step
);

    logic [DIV_W-1:0] pre_cnt;

    assign step = en && !clr && (pre_cnt == div);

    // A div lowered below the running count lets the count wrap through zero naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (clr || step) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= pre_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/ring_counter_prog.sv
// Programmable ring / Johnson / bounce counter with direction, prescaler, load,
// illegal-state correction and registered tick/wrap/err pulses.
module ring_counter_prog
    import ring_counter_prog_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             wrap,
    output logic             err
);

    logic             step;
    dir_e             bdir;
    dir_e             bdir_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] start_pat;
    logic [MAX_W-1:0] q_ext;
    logic             err_next;
    logic             wrap_next;
    logic             go_left;

    step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (load),
        .div   (div),
        .step  (step)
    );

    always_comb begin
        q_ext     = MAX_W'(q);
        q_next    = q;
        bdir_next = (mode == MODE_BOUNCE) ? bdir : dir_e'(dir);
        err_next  = 1'b0;
        wrap_next = 1'b0;
        go_left   = 1'b0;
        start_pat = (mode == MODE_JOHNSON) ? '0 : WIDTH'(1);
        if (step) begin
            unique case (mode_e'(mode))
                MODE_RING: begin
                    if (!is_onehot(q_ext, WIDTH)) begin
                        q_next   = start_pat;
                        err_next = 1'b1;
                    end else if (dir == DIR_RIGHT) begin
                        q_next = {q[0], q[WIDTH-1:1]};
                    end else begin
                        q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                    end
                end
                MODE_JOHNSON: begin
                    if (!is_johnson(q_ext, WIDTH)) begin
                        q_next   = start_pat;
                        err_next = 1'b1;
                    end else if (dir == DIR_RIGHT) begin
                        q_next = {~q[0], q[WIDTH-1:1]};
                    end else begin
                        q_next = {q[WIDTH-2:0], ~q[WIDTH-1]};
                    end
                end
                MODE_HOLD: begin
                end
                MODE_BOUNCE: begin
                    if (!is_onehot(q_ext, WIDTH)) begin
                        q_next    = start_pat;
                        err_next  = 1'b1;
                        bdir_next = DIR_LEFT;
                    end else begin
                        // A loaded value may already sit on the end bit we are heading for.
                        go_left = (bdir == DIR_LEFT) ? !q[WIDTH-1] : q[0];
                        q_next  = go_left ? {q[WIDTH-2:0], 1'b0} : {1'b0, q[WIDTH-1:1]};
                        if (go_left) begin
                            bdir_next = q_next[WIDTH-1] ? DIR_RIGHT : DIR_LEFT;
                        end else begin
                            bdir_next = q_next[0] ? DIR_LEFT : DIR_RIGHT;
                        end
                    end
                end
            endcase
            wrap_next = (mode != MODE_HOLD) && !err_next && (q_next == start_pat);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= WIDTH'(1);
            tick <= 1'b0;
            wrap <= 1'b0;
            err  <= 1'b0;
            bdir <= DIR_LEFT;
        end else if (load) begin
            q    <= load_val;
            tick <= 1'b0;
            wrap <= 1'b0;
            err  <= 1'b0;
            bdir <= dir_e'(dir);
        end else begin
            q    <= q_next;
            tick <= step;
            wrap <= wrap_next;
            err  <= err_next;
            bdir <= bdir_next;
        end
    end

endmodule

// File: tb/tb_ring_counter_prog.sv
// Bench for ring_counter_prog: directed vector table and corner sequences on 8- and 4-bit
// instances, then randomized traffic checked against a position/phase-based reference model.
module tb_ring_counter_prog;
    import ring_counter_prog_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       dir;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] div;

    logic [7:0] q8;
    logic [3:0] q4;
    logic       tick8, wrap8, err8;
    logic       tick4, wrap4, err4;

    int n_cmp  = 0;
    int n_fail = 0;

    int mq[2];
    int mcnt[2];
    bit mbdir[2];
    bit mtick[2];
    bit mwrap[2];
    bit merr[2];
    int ws[2] = '{8, 4};

    typedef struct {
        bit         en;
        logic [1:0] mode;
        bit         dir;
        bit         load;
        logic [7:0] lv;
        logic [7:0] div;
        logic [7:0] q;
        bit         tick;
        bit         wrap;
        bit         err;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    ring_counter_prog #(.WIDTH(8), .DIV_W(8)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .div      (div),
        .q        (q8),
        .tick     (tick8),
        .wrap     (wrap8),
        .err      (err8)
    );

    ring_counter_prog #(.WIDTH(4), .DIV_W(8)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val[3:0]),
        .div      (div),
        .q        (q4),
        .tick     (tick4),
        .wrap     (wrap4),
        .err      (err4)
    );

    // Johnson sequence as a list: phase i < w fills ones from the LSB, later phases clear them.
    function automatic int johnson_state(int w, int i);
        if (i <= w) return (1 << i) - 1;
        return ((1 << w) - 1) & ~((1 << (i - w)) - 1);
    endfunction

    function automatic int johnson_index(int w, int v);
        for (int i = 0; i < 2 * w; i++) begin
            if (johnson_state(w, i) == v) return i;
        end
        return -1;
    endfunction

    function automatic int onehot_pos(int w, int v);
        for (int i = 0; i < w; i++) begin
            if (v == (1 << i)) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k]    = 1;
            mcnt[k]  = 0;
            mbdir[k] = 1'b0;
            mtick[k] = 1'b0;
            mwrap[k] = 1'b0;
            merr[k]  = 1'b0;
        end
    endtask

    task automatic model_clock(int k);
        int w;
        int p;
        int mv;
        bit stp;
        w = ws[k];
        if (load) begin
            mq[k]    = int'(load_val) & ((1 << w) - 1);
            mcnt[k]  = 0;
            mtick[k] = 1'b0;
            mwrap[k] = 1'b0;
            merr[k]  = 1'b0;
            mbdir[k] = dir;
            return;
        end
        stp      = en && (mcnt[k] == int'(div));
        mtick[k] = stp;
        mwrap[k] = 1'b0;
        merr[k]  = 1'b0;
        if (en) mcnt[k] = stp ? 0 : (mcnt[k] + 1) % 256;
        if (mode != MODE_BOUNCE) mbdir[k] = dir;
        if (!stp || mode == MODE_HOLD) return;
        case (mode)
            MODE_RING: begin
                p = onehot_pos(w, mq[k]);
                if (p < 0) begin
                    mq[k] = 1;
                    merr[k] = 1'b1;
                end else begin
                    mq[k] = 1 << ((dir ? p + w - 1 : p + 1) % w);
                end
            end
            MODE_JOHNSON: begin
                p = johnson_index(w, mq[k]);
                if (p < 0) begin
                    mq[k] = 0;
                    merr[k] = 1'b1;
                end else begin
                    mq[k] = johnson_state(w, (dir ? p + 2 * w - 1 : p + 1) % (2 * w));
                end
            end
            default: begin
                p = onehot_pos(w, mq[k]);
                if (p < 0) begin
                    mq[k]    = 1;
                    merr[k]  = 1'b1;
                    mbdir[k] = 1'b0;
                end else begin
                    mv = mbdir[k] ? -1 : 1;
                    if (p + mv < 0 || p + mv >= w) mv = -mv;
                    p = p + mv;
                    mq[k] = 1 << p;
                    mbdir[k] = (mv < 0);
                    if (p == w - 1) mbdir[k] = 1'b1;
                    if (p == 0) mbdir[k] = 1'b0;
                end
            end
        endcase
        mwrap[k] = !merr[k] && (mq[k] == ((mode == MODE_JOHNSON) ? 0 : 1));
    endtask

    task automatic check_value(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output();
        check_value("model q8", 32'(q8), 32'(mq[0]));
        check_value("model tick8", 32'(tick8), 32'(mtick[0]));
        check_value("model wrap8", 32'(wrap8), 32'(mwrap[0]));
        check_value("model err8", 32'(err8), 32'(merr[0]));
        check_value("model q4", 32'(q4), 32'(mq[1]));
        check_value("model tick4", 32'(tick4), 32'(mtick[1]));
        check_value("model wrap4", 32'(wrap4), 32'(mwrap[1]));
        check_value("model err4", 32'(err4), 32'(merr[1]));
    endtask

    task automatic apply_stimulus(bit e, logic [1:0] m, bit d, bit l, logic [7:0] lv, logic [7:0] dv);
        en       = e;
        mode     = m;
        dir      = d;
        load     = l;
        load_val = lv;
        div      = dv;
        model_clock(0);
        model_clock(1);
        @(posedge clk);
        #1;
    endtask

    // Asserts reset away from the clock edge and checks q clears without waiting for a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        check_value("reset q8", 32'(q8), 32'h01);
        check_value("reset q4", 32'(q4), 32'h1);
        check_value("reset tick8", 32'(tick8), 32'h0);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_q;
        int jexp[8];
        int bexp[6];
        logic [7:0] cur_div;

        rst_n = 1'b0;
        en = 1'b0; mode = MODE_RING; dir = 1'b0; load = 1'b0; load_val = 8'h00; div = 8'h00;
        model_reset();
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output();

        for (int i = 0; i < 8; i++) begin
            exp_q = 8'(1 << ((i + 1) % 8));
            vecs[i] = '{1'b1, MODE_RING, 1'b0, 1'b0, 8'h00, 8'h00, exp_q, 1'b1, (i == 7), 1'b0};
        end
        vecs[8]  = '{1'b1, MODE_RING, 1'b0, 1'b1, 8'h05, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, MODE_RING, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, MODE_RING, 1'b0, 1'b1, 8'h10, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, MODE_RING, 1'b1, 1'b0, 8'h00, 8'h00, 8'h08, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, MODE_RING, 1'b1, 1'b0, 8'h00, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, MODE_RING, 1'b1, 1'b0, 8'h00, 8'h00, 8'h04, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i].en, vecs[i].mode, vecs[i].dir, vecs[i].load, vecs[i].lv, vecs[i].div);
            check_value($sformatf("vec%0d q8", i), 32'(q8), 32'(vecs[i].q));
            check_value($sformatf("vec%0d tick8", i), 32'(tick8), 32'(vecs[i].tick));
            check_value($sformatf("vec%0d wrap8", i), 32'(wrap8), 32'(vecs[i].wrap));
            check_value($sformatf("vec%0d err8", i), 32'(err8), 32'(vecs[i].err));
        end

        jexp = '{1, 3, 7, 15, 14, 12, 8, 0};
        apply_stimulus(1'b0, MODE_JOHNSON, 1'b0, 1'b1, 8'h00, 8'd2);
        check_value("johnson load q4", 32'(q4), 32'h0);
        for (int i = 0; i < 24; i++) begin
            apply_stimulus(1'b1, MODE_JOHNSON, 1'b0, 1'b0, 8'h00, 8'd2);
            check_value($sformatf("johnson%0d tick4", i), 32'(tick4), 32'(i % 3 == 2));
            check_value($sformatf("johnson%0d q4", i), 32'(q4), (i < 2) ? 32'h0 : 32'(jexp[(i - 2) / 3]));
            check_value($sformatf("johnson%0d wrap4", i), 32'(wrap4), 32'((i % 3 == 2) && ((i - 2) / 3 == 7)));
        end

        bexp = '{2, 4, 8, 4, 2, 1};
        apply_stimulus(1'b0, MODE_BOUNCE, 1'b0, 1'b1, 8'h01, 8'd0);
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1'b1, MODE_BOUNCE, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 8'd0);
            check_value($sformatf("bounce%0d q4", i), 32'(q4), 32'(bexp[i % 6]));
            check_value($sformatf("bounce%0d wrap4", i), 32'(wrap4), 32'(i % 6 == 5));
            check_value($sformatf("bounce%0d tick4", i), 32'(tick4), 32'h1);
        end

        apply_stimulus(1'b0, MODE_RING, 1'b0, 1'b1, 8'h01, 8'd3);
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b1, MODE_RING, 1'b0, 1'b0, 8'h00, 8'd3);
            check_value("prescale run tick8", 32'(tick8), 32'h0);
        end
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, MODE_RING, 1'b0, 1'b0, 8'h00, 8'd3);
            check_value("prescale hold q8", 32'(q8), 32'h01);
            check_value("prescale hold tick8", 32'(tick8), 32'h0);
        end
        apply_stimulus(1'b1, MODE_RING, 1'b0, 1'b0, 8'h00, 8'd3);
        check_value("prescale resume tick8", 32'(tick8), 32'h0);
        apply_stimulus(1'b1, MODE_RING, 1'b0, 1'b0, 8'h00, 8'd3);
        check_value("prescale step tick8", 32'(tick8), 32'h1);
        check_value("prescale step q8", 32'(q8), 32'h02);

        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b1, MODE_RING, 1'b0, 1'b0, 8'h00, 8'd0);
        end
        check_value("pre-reset q8", 32'(q8), 32'h08);
        do_reset();

        cur_div = 8'd0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) cur_div = 8'($urandom_range(0, 3));
            apply_stimulus($urandom_range(0, 9) < 8,
                           2'($urandom_range(0, 3)),
                           1'($urandom_range(0, 1)),
                           $urandom_range(0, 9) == 0,
                           $urandom_range(0, 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom),
                           cur_div);
            check_output();
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
